// File: rtl/usb_rx.sv
// Full-speed USB receive front end: pin sync, bit recovery, NRZI decode,
// bit unstuffing, SYNC hunt, byte assembly into the packet buffer and CRC16.
module usb_rx #(
    parameter int BUFFER_SIZE   = 1024,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk48,
    input  logic                     reset,
    input  logic                     usb_d_p_in,
    input  logic                     usb_d_n_in,
    output logic                     buffer_write_enable,
    output logic [ADDRESS_WIDTH-1:0] buffer_write_address,
    output logic [7:0]               buffer_write_data,
    output logic                     packet_ready,
    output logic [ADDRESS_WIDTH:0]   packet_length,
    output logic                     packet_error,
    output logic                     crc16_ok
);

    // Line state codes are simply {D+, D-}
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    localparam logic [ADDRESS_WIDTH:0] BUF_BYTES = (ADDRESS_WIDTH+1)'(BUFFER_SIZE);
    localparam logic [15:0]            CRC_RESIDUAL = 16'h800D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_RECEIVE,
        S_EOP,
        S_ERROR
    } state_t;

    // Front end: synchronizers, registered line state, bit phase
    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] line_q;
    logic [1:0] phase_q;

    // Receiver state
    state_t                 state_q;
    logic [1:0]             prev_q;
    logic [2:0]             ones_q;
    logic [7:0]             sync_sr_q;
    logic [3:0]             sync_cnt_q;
    logic [7:0]             data_sr_q;
    logic [2:0]             bit_cnt_q;
    logic [ADDRESS_WIDTH:0] byte_cnt_q;
    logic                   overflow_q;
    logic [15:0]            crc_q;
    logic                   j_seen_q;

    // Registered outputs
    logic                     wr_en_q;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q;
    logic [7:0]               wr_data_q;
    logic                     ready_q;
    logic [ADDRESS_WIDTH:0]   length_q;
    logic                     error_q;
    logic                     crc_ok_q;

    // Decode helpers for the current sample
    logic        sample_d;
    logic        line_is_jk_d;
    logic        rx_bit_d;
    logic        stuff_hit_d;
    logic        crc_fb_d;
    logic [15:0] crc_d;
    logic [2:0]  ones_d;
    logic [7:0]  sync_sr_d;
    logic [7:0]  data_sr_d;

    // Two-flop pin synchronizer, line register, and phase realignment on edges
    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            meta_q  <= 2'b00;
            sync_q  <= 2'b00;
            line_q  <= 2'b00;
            phase_q <= 2'd0;
        end else begin
            meta_q  <= {usb_d_p_in, usb_d_n_in};
            sync_q  <= meta_q;
            line_q  <= sync_q;
            phase_q <= (sync_q != line_q) ? 2'd0 : phase_q + 2'd1;
        end
    end

    // NRZI decode, stuffing detect, next CRC and shift register values
    always_comb begin
        sample_d     = (phase_q == 2'd2);
        line_is_jk_d = (line_q == LINE_J) || (line_q == LINE_K);
        rx_bit_d     = (line_q == prev_q);
        stuff_hit_d  = (ones_q == 3'd6);
        crc_fb_d     = rx_bit_d ^ crc_q[15];
        crc_d        = {crc_q[14:0], 1'b0} ^ (crc_fb_d ? 16'h8005 : 16'h0000);
        ones_d       = rx_bit_d ? ones_q + 3'd1 : 3'd0;
        sync_sr_d    = {rx_bit_d, sync_sr_q[7:1]};
        data_sr_d    = {rx_bit_d, data_sr_q[7:1]};
    end

    // Packet FSM with byte writes and end-of-packet reporting
    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            prev_q     <= LINE_J;
            ones_q     <= 3'd0;
            sync_sr_q  <= 8'h00;
            sync_cnt_q <= 4'd0;
            data_sr_q  <= 8'h00;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            overflow_q <= 1'b0;
            crc_q      <= 16'hFFFF;
            j_seen_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            ready_q    <= 1'b0;
            length_q   <= '0;
            error_q    <= 1'b0;
            crc_ok_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            ready_q <= 1'b0;
            if (sample_d) begin
                case (state_q)
                    S_IDLE: begin
                        if (line_q == LINE_K) begin
                            // First K of SYNC decodes to 0; an all-zero register already holds it
                            state_q    <= S_SYNC;
                            prev_q     <= LINE_K;
                            sync_sr_q  <= 8'h00;
                            sync_cnt_q <= 4'd1;
                            ones_q     <= 3'd0;
                        end else begin
                            prev_q <= LINE_J;
                        end
                    end
                    S_SYNC: begin
                        if (!line_is_jk_d) begin
                            state_q <= S_IDLE;
                            prev_q  <= LINE_J;
                        end else begin
                            prev_q     <= line_q;
                            sync_cnt_q <= sync_cnt_q + 4'd1;
                            if (stuff_hit_d && rx_bit_d) begin
                                state_q <= S_IDLE;
                                prev_q  <= LINE_J;
                            end else if (stuff_hit_d) begin
                                ones_q <= 3'd0;
                                if (sync_cnt_q == 4'd15) begin
                                    state_q <= S_IDLE;
                                    prev_q  <= LINE_J;
                                end
                            end else begin
                                // The trailing 1 of SYNC counts toward stuffing of the PID
                                ones_q    <= ones_d;
                                sync_sr_q <= sync_sr_d;
                                if (sync_sr_d == 8'h80) begin
                                    state_q    <= S_RECEIVE;
                                    bit_cnt_q  <= 3'd0;
                                    byte_cnt_q <= '0;
                                    overflow_q <= 1'b0;
                                    crc_q      <= 16'hFFFF;
                                    data_sr_q  <= 8'h00;
                                end else if (sync_cnt_q == 4'd15) begin
                                    state_q <= S_IDLE;
                                    prev_q  <= LINE_J;
                                end
                            end
                        end
                    end
                    S_RECEIVE: begin
                        if (line_q == LINE_SE0) begin
                            state_q <= S_EOP;
                        end else if (line_q == LINE_SE1) begin
                            state_q  <= S_ERROR;
                            j_seen_q <= 1'b0;
                        end else begin
                            prev_q <= line_q;
                            if (stuff_hit_d && rx_bit_d) begin
                                state_q  <= S_ERROR;
                                j_seen_q <= 1'b0;
                            end else if (stuff_hit_d) begin
                                ones_q <= 3'd0;
                            end else begin
                                ones_q    <= ones_d;
                                data_sr_q <= data_sr_d;
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                // PID bits are excluded from the CRC
                                if (byte_cnt_q != '0) begin
                                    crc_q <= crc_d;
                                end
                                if (bit_cnt_q == 3'd7) begin
                                    if (byte_cnt_q < BUF_BYTES) begin
                                        wr_en_q    <= 1'b1;
                                        wr_addr_q  <= byte_cnt_q[ADDRESS_WIDTH-1:0];
                                        wr_data_q  <= data_sr_d;
                                        byte_cnt_q <= byte_cnt_q + 1'b1;
                                    end else begin
                                        overflow_q <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    S_EOP: begin
                        // Ride out the SE0 bits; the first non-SE0 sample decides
                        if (line_q != LINE_SE0) begin
                            ready_q  <= 1'b1;
                            length_q <= byte_cnt_q;
                            error_q  <= (line_q != LINE_J) || (bit_cnt_q != 3'd0) || overflow_q;
                            crc_ok_q <= (crc_q == CRC_RESIDUAL);
                            state_q  <= S_IDLE;
                            prev_q   <= LINE_J;
                        end
                    end
                    S_ERROR: begin
                        if (line_q == LINE_J) begin
                            if (j_seen_q) begin
                                ready_q  <= 1'b1;
                                length_q <= byte_cnt_q;
                                error_q  <= 1'b1;
                                crc_ok_q <= (crc_q == CRC_RESIDUAL);
                                state_q  <= S_IDLE;
                                prev_q   <= LINE_J;
                            end else begin
                                j_seen_q <= 1'b1;
                            end
                        end else begin
                            j_seen_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        prev_q  <= LINE_J;
                    end
                endcase
            end
        end
    end

    assign buffer_write_enable  = wr_en_q;
    assign buffer_write_address = wr_addr_q;
    assign buffer_write_data    = wr_data_q;
    assign packet_ready         = ready_q;
    assign packet_length        = length_q;
    assign packet_error         = error_q;
    assign crc16_ok             = crc_ok_q;

endmodule
